// File: rtl/rom_load_pkg.sv
// Shared types for the ROM download sequencer: FSM states, region index, region count.
package rom_load_pkg;

  localparam int NREG = 4;

  typedef logic [1:0] region_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_e;

endpackage

// File: rtl/rom_load_seq_if.sv
// ioctl download bus, CPU address and ROM RAM port bundle.
// Master = download source / CPU side, slave = the sequencer.
interface rom_load_seq_if;

  logic                           ioctl_download;
  logic [26:0]                    ioctl_addr;
  logic [15:0]                    ioctl_dout;
  logic                           ioctl_wr;
  logic [15:0]                    cpu_ab;
  logic [rom_load_pkg::NREG-1:0]  rom_we;
  logic [15:0]                    rom_addr;
  logic [7:0]                     rom_din;
  logic                           cpu_hold;
  logic                           load_done;
  logic                           err_range;
  logic                           sum_ok;

  modport master (
    output ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr, cpu_ab,
    input  rom_we, rom_addr, rom_din, cpu_hold, load_done, err_range, sum_ok
  );

  modport slave (
    input  ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr, cpu_ab,
    output rom_we, rom_addr, rom_din, cpu_hold, load_done, err_range, sum_ok
  );

endinterface

// File: rtl/rom_region_dec.sv
// Combinational download-address decoder: one-hot region, region-relative offset, out-of-range flag.
module rom_region_dec
  import rom_load_pkg::*;
#(
  parameter logic [26:0] R1_BASE  = 27'h04000,
  parameter logic [26:0] R2_BASE  = 27'h0C000,
  parameter logic [26:0] R3_BASE  = 27'h10000,
  parameter logic [26:0] LOAD_END = 27'h30000
) (
  input  logic [26:0]     addr_i,
  output logic [NREG-1:0] onehot_o,
  output logic [15:0]     offset_o,
  output logic            oor_o
);

  localparam logic [26:0] BASES [NREG] = '{27'h0, R1_BASE, R2_BASE, R3_BASE};

  logic [NREG-1:1] ge;
  region_t         region;
  logic [26:0]     diff;
  logic            unused_hi;

  // Region 0 starts at address zero, so only the upper bases need a compare.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_ge
      assign ge[gi] = (addr_i >= BASES[gi]);
    end
  endgenerate

  always_comb begin
    region = '0;
    for (int n = 1; n < NREG; n++) begin
      if (ge[n]) region = region_t'(n);
    end
  end

  assign diff      = addr_i - BASES[region];
  assign offset_o  = diff[15:0];
  assign onehot_o  = NREG'(1) << region;
  assign oor_o     = (addr_i >= LOAD_END);
  assign unused_hi = &{1'b0, diff[26:16]};

endmodule

// File: rtl/rom_load_seq.sv
// Sequences an ioctl ROM download into region ROM RAMs and muxes the ROM address with the CPU bus.
// Optional build macro ROM_CHECKSUM_EN adds a byte-sum check reported on sum_ok.
module rom_load_seq
  import rom_load_pkg::*;
#(
  parameter logic [26:0] R1_BASE  = 27'h04000,
  parameter logic [26:0] R2_BASE  = 27'h0C000,
  parameter logic [26:0] R3_BASE  = 27'h10000,
  parameter logic [26:0] LOAD_END = 27'h30000,
  parameter int unsigned HOLD_CYC = 16
`ifdef ROM_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM  = 16'h0000
`endif
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  rom_load_seq_if.slave  bus
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [NREG-1:0] we_q;
  logic [15:0]     addr_q;
  logic [7:0]      din_q;
  logic            err_q;

  logic [NREG-1:0] dec_onehot;
  logic [15:0]     dec_offset;
  logic            dec_oor;
  logic            wr_hit;
  logic            load_entry;
  logic            unused_dout;

  rom_region_dec #(
    .R1_BASE  (R1_BASE),
    .R2_BASE  (R2_BASE),
    .R3_BASE  (R3_BASE),
    .LOAD_END (LOAD_END)
  ) u_dec (
    .addr_i   (bus.ioctl_addr),
    .onehot_o (dec_onehot),
    .offset_o (dec_offset),
    .oor_o    (dec_oor)
  );

  assign wr_hit      = (state_q == LOAD) && bus.ioctl_wr;
  assign load_entry  = (state_d == LOAD) && (state_q != LOAD);
  assign unused_dout = &{1'b0, bus.ioctl_dout[15:8]};

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE:  if (bus.ioctl_download) state_d = LOAD;
      LOAD:  if (!bus.ioctl_download) state_d = FLUSH;
      FLUSH: begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_INIT;
      end
      HOLD: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end else if (hold_cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      RUN:   if (bus.ioctl_download) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      we_q       <= '0;
      addr_q     <= 16'd0;
      din_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      we_q       <= '0;
      if (wr_hit) begin
        addr_q <= dec_offset;
        din_q  <= bus.ioctl_dout[7:0];
        if (dec_oor) err_q <= 1'b1;
        else         we_q  <= dec_onehot;
      end
      // Entry only happens from a non-LOAD state, so it never races a write.
      if (load_entry) err_q <= 1'b0;
    end
  end

  assign bus.rom_we    = we_q;
  assign bus.rom_addr  = (state_q == LOAD || state_q == FLUSH) ? addr_q : bus.cpu_ab;
  assign bus.rom_din   = din_q;
  assign bus.cpu_hold  = (state_q != RUN);
  assign bus.load_done = (state_q == RUN);
  assign bus.err_range = err_q;

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        sum_ok_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q    <= 16'd0;
      sum_ok_q <= 1'b0;
    end else begin
      if (load_entry)             sum_q <= 16'd0;
      else if (wr_hit && !dec_oor) sum_q <= sum_q + {8'h00, bus.ioctl_dout[7:0]};
      sum_ok_q <= (state_d == RUN) && (sum_q == EXP_SUM);
    end
  end

  assign bus.sum_ok = sum_ok_q;
`else
  assign bus.sum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rom_load_seq.sv
// Directed bench for rom_load_seq: region decode, write latency, range error, hold timing, checksum.
module tb_rom_load_seq;

  localparam int HOLD_CYC = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  logic exp_sum_good;
  logic exp_sum_bad;
  logic exp_sum_idle;

  rom_load_seq_if bus_if ();

`ifdef ROM_CHECKSUM_EN
  rom_load_seq #(.HOLD_CYC(HOLD_CYC), .EXP_SUM(16'h0102)) dut (
`else
  rom_load_seq #(.HOLD_CYC(HOLD_CYC)) dut (
`endif
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [26:0] a, input logic [7:0] d);
    bus_if.ioctl_addr = a;
    bus_if.ioctl_dout = {8'h5A, d};
    bus_if.ioctl_wr   = 1'b1;
  endtask

  // Drop download and count edges until the CPUs are released.
  task automatic drop_and_wait(output int cycles);
    bus_if.ioctl_download = 1'b0;
    tick();
    cycles = 1;
    while (bus_if.cpu_hold && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
`ifdef ROM_CHECKSUM_EN
    exp_sum_good = 1'b1;
    exp_sum_bad  = 1'b0;
    exp_sum_idle = 1'b0;
`else
    exp_sum_good = 1'b1;
    exp_sum_bad  = 1'b1;
    exp_sum_idle = 1'b1;
`endif
    rst_n                 = 1'b0;
    bus_if.ioctl_download = 1'b0;
    bus_if.ioctl_addr     = '0;
    bus_if.ioctl_dout     = '0;
    bus_if.ioctl_wr       = 1'b0;
    bus_if.cpu_ab         = 16'h1234;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("reset_hold", bus_if.cpu_hold, 1);
    check("reset_we", bus_if.rom_we, 0);
    check("reset_addr_cpu", bus_if.rom_addr, 16'h1234);
    check("reset_din", bus_if.rom_din, 0);
    check("reset_done", bus_if.load_done, 0);
    check("reset_err", bus_if.err_range, 0);
    check("reset_sum_ok", bus_if.sum_ok, exp_sum_idle);
    bus_if.cpu_ab = 16'h5678;
    #1;
    check("idle_addr_comb", bus_if.rom_addr, 16'h5678);

    // Strobe outside LOAD is ignored entirely.
    strobe(27'h30000, 8'h11);
    tick();
    bus_if.ioctl_wr = 1'b0;
    check("idle_wr_we", bus_if.rom_we, 0);
    check("idle_wr_err", bus_if.err_range, 0);
    repeat (4) tick();
    check("idle_still_hold", bus_if.cpu_hold, 1);

    bus_if.ioctl_download = 1'b1;
    tick();

    strobe(27'h00000, 8'hAA); tick(); bus_if.ioctl_wr = 1'b0;
    check("w0_we", bus_if.rom_we, 4'b0001);
    check("w0_addr", bus_if.rom_addr, 16'h0000);
    check("w0_din", bus_if.rom_din, 8'hAA);
    tick();
    check("w0_one_cycle", bus_if.rom_we, 0);

    strobe(27'h03FFF, 8'hBB); tick(); bus_if.ioctl_wr = 1'b0;
    check("w1_we", bus_if.rom_we, 4'b0001);
    check("w1_addr", bus_if.rom_addr, 16'h3FFF);
    check("w1_din", bus_if.rom_din, 8'hBB);
    tick();

    strobe(27'h04000, 8'hCC); tick(); bus_if.ioctl_wr = 1'b0;
    check("w2_we", bus_if.rom_we, 4'b0010);
    check("w2_addr", bus_if.rom_addr, 16'h0000);
    check("w2_din", bus_if.rom_din, 8'hCC);
    tick();

    strobe(27'h0C000, 8'h11); tick();
    check("b2b0_we", bus_if.rom_we, 4'b0100);
    check("b2b0_addr", bus_if.rom_addr, 16'h0000);
    check("b2b0_din", bus_if.rom_din, 8'h11);
    strobe(27'h0C001, 8'h22); tick();
    check("b2b1_we", bus_if.rom_we, 4'b0100);
    check("b2b1_addr", bus_if.rom_addr, 16'h0001);
    check("b2b1_din", bus_if.rom_din, 8'h22);
    strobe(27'h0C002, 8'h33); tick();
    bus_if.ioctl_wr = 1'b0;
    check("b2b2_we", bus_if.rom_we, 4'b0100);
    check("b2b2_addr", bus_if.rom_addr, 16'h0002);
    check("b2b2_din", bus_if.rom_din, 8'h33);
    tick();
    check("b2b_end_we", bus_if.rom_we, 0);

    strobe(27'h2FFFF, 8'h44); tick(); bus_if.ioctl_wr = 1'b0;
    check("gfx_top_we", bus_if.rom_we, 4'b1000);
    check("gfx_top_addr", bus_if.rom_addr, 16'hFFFF);
    tick();

    strobe(27'h30000, 8'h55); tick(); bus_if.ioctl_wr = 1'b0;
    check("oor_we", bus_if.rom_we, 0);
    check("oor_err", bus_if.err_range, 1);
    check("load_hold", bus_if.cpu_hold, 1);
    tick();

    // Strobe in the same cycle the download drops lands during FLUSH.
    strobe(27'h00010, 8'h77);
    bus_if.ioctl_download = 1'b0;
    tick();
    bus_if.ioctl_wr = 1'b0;
    check("flush_we", bus_if.rom_we, 4'b0001);
    check("flush_addr", bus_if.rom_addr, 16'h0010);
    check("flush_din", bus_if.rom_din, 8'h77);
    check("flush_hold", bus_if.cpu_hold, 1);
    cyc = 1;
    while (bus_if.cpu_hold && cyc < 100) begin
      tick();
      cyc++;
    end
    check("hold_release_cycles", cyc, HOLD_CYC + 2);
    check("run_done", bus_if.load_done, 1);
    check("run_err_sticky", bus_if.err_range, 1);
    check("run_addr_cpu", bus_if.rom_addr, 16'h5678);

    // Second download: clears the error, sums to the expected value.
    bus_if.ioctl_download = 1'b1;
    tick();
    check("dl2_err_clr", bus_if.err_range, 0);
    check("dl2_done_clr", bus_if.load_done, 0);
    check("dl2_hold", bus_if.cpu_hold, 1);
    check("dl2_sum_ok_load", bus_if.sum_ok, exp_sum_idle);
    strobe(27'h00000, 8'hFF); tick();
    strobe(27'h00001, 8'h03); tick();
    bus_if.ioctl_wr = 1'b0;
    drop_and_wait(cyc);
    check("dl2_cycles", cyc, HOLD_CYC + 2);
    tick();
    check("dl2_sum_ok", bus_if.sum_ok, exp_sum_good);

    bus_if.ioctl_download = 1'b1;
    tick();
    strobe(27'h00000, 8'hFF); tick();
    strobe(27'h00001, 8'h02); tick();
    bus_if.ioctl_wr = 1'b0;
    drop_and_wait(cyc);
    check("dl3_cycles", cyc, HOLD_CYC + 2);
    tick();
    check("dl3_sum_bad", bus_if.sum_ok, exp_sum_bad);

    // Download re-raised during HOLD returns straight to LOAD.
    bus_if.ioctl_download = 1'b1;
    tick();
    bus_if.ioctl_download = 1'b0;
    repeat (5) tick();
    check("rehold_hold", bus_if.cpu_hold, 1);
    bus_if.ioctl_download = 1'b1;
    tick();
    strobe(27'h04001, 8'h99); tick(); bus_if.ioctl_wr = 1'b0;
    check("reload_we", bus_if.rom_we, 4'b0010);
    check("reload_addr", bus_if.rom_addr, 16'h0001);
    check("reload_din", bus_if.rom_din, 8'h99);
    strobe(27'h30000, 8'h00); tick();
    check("reload_err", bus_if.err_range, 1);

    // Reset with a strobe pending drops the write and clears everything.
    strobe(27'h00005, 8'h66);
    rst_n = 1'b0;
    tick();
    bus_if.ioctl_wr = 1'b0;
    check("rst_we", bus_if.rom_we, 0);
    check("rst_err", bus_if.err_range, 0);
    check("rst_hold", bus_if.cpu_hold, 1);
    check("rst_din", bus_if.rom_din, 0);
    check("rst_addr_cpu", bus_if.rom_addr, 16'h5678);
    rst_n = 1'b1;
    bus_if.ioctl_download = 1'b0;
    tick();
    check("post_rst_done", bus_if.load_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
